// File: rtl/home_status_logger_if.sv
// Event port between home_status_logger (master) and the draining host (slave).
// ev_time exists only when HOME_LOG_TIMESTAMP_EN is defined.
interface home_status_logger_if #(
    parameter int TS_WIDTH = 16
) ();
    logic       ev_valid;
    logic       ev_rdy;
    logic [2:0] ev_code;
    logic [2:0] ev_prev;
`ifdef HOME_LOG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ev_time;
`endif

    modport master (
        input  ev_rdy,
        output ev_valid,
        output ev_code,
        output ev_prev
`ifdef HOME_LOG_TIMESTAMP_EN
        , output ev_time
`endif
    );

    modport slave (
        output ev_rdy,
        input  ev_valid,
        input  ev_code,
        input  ev_prev
`ifdef HOME_LOG_TIMESTAMP_EN
        , input  ev_time
`endif
    );
endinterface

// File: rtl/home_status_logger.sv
// Glitch-filtered state-change logger with a show-ahead event FIFO and sticky flags.
// Optional per-event timestamps are enabled with `define HOME_LOG_TIMESTAMP_EN.
module home_status_logger #(
    parameter int STABLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int TS_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  state_code_i,
    input  logic                        clear_i,
    home_status_logger_if.master        ev_if,
    output logic                        alarm_latched_o,
    output logic                        overflow_o,
    output logic                        illegal_seen_o,
    output logic [7:0]                  alarm_count_o
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef HOME_LOG_TIMESTAMP_EN
    localparam int EW = 6 + TS_WIDTH;
`else
    localparam int EW = 6;
`endif
    localparam logic [2:0] CODE_ALARM   = 3'b011;
    localparam logic [2:0] CODE_ILLEGAL = 3'b111;

    logic [2:0]    s_q;
    logic [2:0]    acc_q, acc_d;
    logic [2:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          accept;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic [EW-1:0] entry_mem [FIFO_DEPTH];
    logic [EW-1:0] wr_entry, rd_entry;
    logic          alarm_latched_q, overflow_q, illegal_seen_q;
    logic [7:0]    alarm_count_q, alarm_count_d, alarm_base;

    // Filter: candidate must be seen STABLE_CYCLES consecutive samples to be accepted.
    always_comb begin
        acc_d   = acc_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CW'(1);
        accept  = 1'b0;
        if (s_q == acc_q) begin
            cand_d = acc_q;
            cnt_d  = '0;
        end else begin
            if (s_q != cand_q) begin
                cand_d  = s_q;
                cnt_inc = CW'(1);
            end
            if (cnt_inc == CW'(STABLE_CYCLES)) begin
                accept = 1'b1;
                cnt_d  = '0;
                if (s_q != CODE_ILLEGAL) acc_d = s_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    logic push, pop, full, push_ok, ovf_set, alarm_set, illegal_set;

    assign push        = accept && (s_q != CODE_ILLEGAL);
    assign illegal_set = accept && (s_q == CODE_ILLEGAL);
    assign alarm_set   = push && (s_q == CODE_ALARM);
    assign full        = (occ_q == (AW+1)'(FIFO_DEPTH));
    assign pop         = (occ_q != '0) && ev_if.ev_rdy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok     = push && (!full || pop);
    assign ovf_set     = push && full && !pop;

    always_comb begin
        occ_d = occ_q;
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        alarm_base    = clear_i ? 8'd0 : alarm_count_q;
        alarm_count_d = alarm_base;
        if (alarm_set && alarm_base != 8'hFF) alarm_count_d = alarm_base + 8'd1;
    end

`ifdef HOME_LOG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_WIDTH'(1);
    end
    assign wr_entry = {ts_q, acc_q, s_q};
`else
    assign wr_entry = {acc_q, s_q};
`endif

    always_ff @(posedge clk) begin
        if (push_ok) entry_mem[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q             <= 3'b000;
            acc_q           <= 3'b000;
            cand_q          <= 3'b000;
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            alarm_latched_q <= 1'b0;
            overflow_q      <= 1'b0;
            illegal_seen_q  <= 1'b0;
            alarm_count_q   <= 8'd0;
        end else begin
            s_q             <= state_code_i;
            acc_q           <= acc_d;
            cand_q          <= cand_d;
            cnt_q           <= cnt_d;
            occ_q           <= occ_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            alarm_latched_q <= (alarm_latched_q && !clear_i) || alarm_set;
            overflow_q      <= (overflow_q && !clear_i) || ovf_set;
            illegal_seen_q  <= (illegal_seen_q && !clear_i) || illegal_set;
            alarm_count_q   <= alarm_count_d;
        end
    end

    // Head entry is forced to zero while empty so the outputs read 000 after reset.
    assign rd_entry       = (occ_q != '0) ? entry_mem[rd_ptr_q] : '0;
    assign ev_if.ev_valid = (occ_q != '0);
    assign ev_if.ev_code  = rd_entry[2:0];
    assign ev_if.ev_prev  = rd_entry[5:3];
`ifdef HOME_LOG_TIMESTAMP_EN
    assign ev_if.ev_time  = rd_entry[EW-1:6];
`endif

    assign alarm_latched_o = alarm_latched_q;
    assign overflow_o      = overflow_q;
    assign illegal_seen_o  = illegal_seen_q;
    assign alarm_count_o   = alarm_count_q;
endmodule
